// File: rtl/clk_div_arb_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_arb_pkg
// Shared types and default widths for the clock-divider arbiter block.
//   state_t    : controller states (IDLE, RUN, DONE)
//   CNT_W_DEF  : default width of the half-period compare value and counter
//   TGL_W_DEF  : default width of the toggle-count request
// ---------------------------------------------------------------------------
package clk_div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 32;
    localparam int TGL_W_DEF = 16;

endpackage

// File: rtl/clk_div_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// N-way round-robin arbiter. The pick is purely combinational from the
// request vector and the stored pointer; the pointer moves to the winner
// whenever 'update' is high and at least one request is present, so the
// winner becomes lowest priority on the next arbitration.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (pointer -> N-1)
//   req      in   N  request vector
//   update   in   1  commit the current pick into the pointer
//   pick     out  N  one-hot winner (zero when req is zero)
//   pick_idx out  IDX_W  binary index of the winner
//   any      out  1  at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             update,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    assign any = |req;

    // Scan upward starting one past the last winner, wrapping around, and
    // take the first requester seen.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick_idx    = cand;
                pick[cand]  = 1'b1;
            end
        end
    end

    // Pointer starts at N-1 so that index 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDX_W'(N - 1);
        end else if (update && any) begin
            ptr <= pick_idx;
        end
    end

endmodule

// File: rtl/clk_div_arbiter.sv
// ---------------------------------------------------------------------------
// clk_div_arbiter
// Shares one programmable clock divider between N requesters. A round-robin
// arbiter picks a requester, its half-period H and toggle count T are
// latched, divided_clk toggles every H+1 clk cycles for T toggles, then a
// one-cycle done pulse is issued for the granted index and the grant drops.
// Optional build macro: CLK_DIV_ARB_ABORT_EN -- when defined, the granted
// requester dropping req during RUN aborts the run (back to IDLE, no done).
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   req           in   N        per-requester request level
//   half_period   in   N*CNT_W  packed H values, slice i for requester i
//   toggle_count  in   N*TGL_W  packed T values, slice i for requester i
//   gnt           out  N        registered one-hot grant
//   done          out  N        one-cycle completion pulse
//   busy          out  1        high whenever not IDLE
//   divided_clk   out  1        shared divided clock
// ---------------------------------------------------------------------------
module clk_div_arbiter
    import clk_div_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TGL_W = TGL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*CNT_W-1:0] half_period,
    input  logic [N*TGL_W-1:0] toggle_count,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic               busy,
    output logic               divided_clk
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] h_reg;
    logic [TGL_W-1:0] toggles_left;
    logic [IDX_W-1:0] win_idx;

    logic [N-1:0]     pick;
    logic [IDX_W-1:0] pick_idx;
    logic             req_any;
    logic             arb_update;
    logic [CNT_W-1:0] sel_h;
    logic [TGL_W-1:0] sel_t;

    // Arbitration only happens in IDLE; the pointer is committed on the
    // same edge that raises the grant.
    assign arb_update = (state == IDLE);

    rr_arbiter #(.N(N)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .update   (arb_update),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (req_any)
    );

    assign sel_h = half_period[int'(pick_idx)*CNT_W +: CNT_W];
    assign sel_t = toggle_count[int'(pick_idx)*TGL_W +: TGL_W];

    // Main controller. All outputs are registered here. DONE is normally
    // entered with done already set and lasts one cycle; a T=0 request
    // enters DONE with done clear, so DONE spends one extra cycle raising
    // done before returning to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= '0;
            done         <= '0;
            busy         <= 1'b0;
            divided_clk  <= 1'b0;
            counter      <= '0;
            h_reg        <= '0;
            toggles_left <= '0;
            win_idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt         <= '0;
                    done        <= '0;
                    busy        <= 1'b0;
                    divided_clk <= 1'b0;
                    counter     <= '0;
                    if (req_any) begin
                        h_reg        <= sel_h;
                        toggles_left <= sel_t;
                        win_idx      <= pick_idx;
                        gnt          <= pick;
                        busy         <= 1'b1;
                        state        <= (sel_t != '0) ? RUN : DONE;
                    end
                end

                RUN: begin
`ifdef CLK_DIV_ARB_ABORT_EN
                    if (!req[win_idx]) begin
                        state        <= IDLE;
                        gnt          <= '0;
                        busy         <= 1'b0;
                        divided_clk  <= 1'b0;
                        counter      <= '0;
                        toggles_left <= '0;
                    end else
`endif
                    if (counter == h_reg) begin
                        counter      <= '0;
                        divided_clk  <= ~divided_clk;
                        toggles_left <= toggles_left - TGL_W'(1);
                        if (toggles_left == TGL_W'(1)) begin
                            state <= DONE;
                            done  <= gnt;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                DONE: begin
                    if (done == '0) begin
                        done <= gnt;
                    end else begin
                        state       <= IDLE;
                        done        <= '0;
                        gnt         <= '0;
                        busy        <= 1'b0;
                        divided_clk <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
